// File: rtl/aes_pkg.sv
// Shared AES-128 types, S-box table and round helper functions.
// Byte 0 of a 128-bit block sits in bits 127:120, column-major.
package aes_pkg;

  typedef logic [127:0] state_t;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r rotates left by r columns
  function automatic state_t shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup.
// One byte in, one substituted byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  assign y = SBOX[x];

endmodule

// File: rtl/aes128_enc_core.sv
// Iterative AES-128 encryption core: one round per clock,
// round keys expanded on the fly alongside the state.
module aes128_enc_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic         busy
);

  fsm_t        fsm;
  state_t      state_reg;
  state_t      rk_reg;
  logic [3:0]  rnd;
  logic [7:0]  rcon;

  state_t      sub;
  state_t      sr;
  state_t      rnd_out;
  state_t      next_rk;
  logic [31:0] rot;
  logic [31:0] sw;
  logic [31:0] tmp;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sbox (
      .x(state_reg[127-8*i -: 8]),
      .y(sub[127-8*i -: 8])
    );
  end

  assign rot = {rk_reg[23:0], rk_reg[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_subw
    aes_sbox u_sbox (
      .x(rot[31-8*j -: 8]),
      .y(sw[31-8*j -: 8])
    );
  end

  assign tmp = sw ^ {rcon, 24'h0};
  assign next_rk[127:96] = rk_reg[127:96] ^ tmp;
  assign next_rk[95:64] = rk_reg[95:64] ^ next_rk[127:96];
  assign next_rk[63:32] = rk_reg[63:32] ^ next_rk[95:64];
  assign next_rk[31:0] = rk_reg[31:0] ^ next_rk[63:32];

  // Final round drops MixColumns
  assign sr = shift_rows(sub);
  assign rnd_out = (rnd == 4'(NR)) ? sr : mix_columns(sr);

  assign in_ready = (fsm == IDLE);
  assign ct = state_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm <= IDLE;
      state_reg <= '0;
      rk_reg <= '0;
      rnd <= '0;
      rcon <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_reg <= pt ^ key;
            rk_reg <= key;
            rnd <= 4'd1;
            rcon <= 8'h01;
            busy <= 1'b1;
            fsm <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= rnd_out ^ next_rk;
          rk_reg <= next_rk;
          rcon <= xtime(rcon);
          rnd <= rnd + 4'd1;
          if (rnd == 4'(NR)) begin
            out_valid <= 1'b1;
            fsm <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy <= 1'b0;
            fsm <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy <= 1'b0;
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_enc_core.sv
// Scoreboard bench for aes128_enc_core against a byte-level
// AES-128 model whose S-box is derived from GF(2^8) arithmetic.
module tb_aes128_enc_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;
  logic         busy;

  aes128_enc_core dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .pt(pt),
    .key(key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ct(ct),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] rk;
    int           acc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] sbox_m[256];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         acc_last = 0;
  int         acc_prev = 0;
  bit         lat_done = 0;

  always @(posedge clk) cyc++;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv, b;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      if (a != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
      end
      b = inv;
      sbox_m[a] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] p, input logic [127:0] k,
                                           output logic [127:0] last_rk);
    logic [31:0]  w[44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s[16];
    logic [7:0]   u[16];
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) u[q+4*c] = s[q+4*((c+q)%4)];
      for (int c = 0; c < 4; c++) begin
        for (int q = 0; q < 4; q++) begin
          if (r < 10)
            s[q+4*c] = gmul(u[4*c+q], 8'h02) ^ gmul(u[4*c+(q+1)%4], 8'h03)
                     ^ u[4*c+(q+2)%4] ^ u[4*c+(q+3)%4];
          else
            s[q+4*c] = u[q+4*c];
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= w[4*r+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    last_rk = {w[40], w[41], w[42], w[43]};
    return o;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Accept monitor: push the model's answer at the handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && in_valid && in_ready) begin
      e.ct = ref_enc(pt, key, e.rk);
      e.acc = cyc;
      sb.push_back(e);
      acc_prev = acc_last;
      acc_last = cyc;
    end
  end

  // Output monitor: latency on first out_valid, data on handshake
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        timeout("unexpected_out_valid");
      end else begin
        if (!lat_done) begin
          chk("latency", 128'(cyc - sb[0].acc), 128'd11);
          lat_done = 1;
        end
        if (out_ready) begin
          chk("ct_scoreboard", ct, sb[0].ct);
          void'(sb.pop_front());
          lat_done = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] p, input logic [127:0] k, input bit keep);
    bit ok;
    ok = 0;
    pt = p;
    key = k;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("send_accept");
    step();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("wait_out_valid");
  endtask

  task automatic drain(input bit rand_rdy);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && in_ready) begin
        ok = 1;
        break;
      end
      step();
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
    end
    if (!ok) timeout("drain");
    out_ready = 1'b1;
    step();
  endtask

  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [127:0] zrk, zct, rp, rk;
    build_sbox();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    pt = '0;
    key = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ct", ct, 128'd0);
    step();
    rst_n = 1'b1;
    step();

    send(B_PT, B_KEY, 0);
    wait_valid();
    chk("appb_ct", ct, B_CT);
    step();
    drain(0);

    send(C_PT, C_KEY, 0);
    wait_valid();
    chk("appc1_ct", ct, C_CT);
    step();
    drain(0);

    zct = ref_enc('0, '0, zrk);
    send('0, '0, 0);
    wait_valid();
    chk("zero_ct", ct, Z_CT);
    chk("zero_model", zct, Z_CT);
    chk("zero_rk10", dut.rk_reg, zrk);
    step();
    drain(0);

    // Backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    send(C_PT, C_KEY, 0);
    wait_valid();
    step();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'(i % 2);
      pt = 128'($urandom);
      @(negedge clk);
      chk("bp_ct_stable", ct, C_CT);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_rel_out_valid", 128'(out_valid), 128'd0);
    chk("bp_rel_in_ready", 128'(in_ready), 128'd1);
    step();
    drain(0);

    // Reset mid-round at T+5
    send(B_PT, B_KEY, 0);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("mrst_out_valid", 128'(out_valid), 128'd0);
    chk("mrst_in_ready", 128'(in_ready), 128'd1);
    chk("mrst_busy", 128'(busy), 128'd0);
    sb.delete();
    lat_done = 0;
    step();
    rst_n = 1'b1;
    step();
    send(B_PT, B_KEY, 0);
    wait_valid();
    chk("mrst_appb_ct", ct, B_CT);
    step();
    drain(0);

    // Back-to-back with in_valid held high
    send(B_PT, B_KEY, 1);
    send(C_PT, C_KEY, 0);
    @(negedge clk);
    chk("b2b_gap", 128'(acc_last - acc_prev), 128'd12);
    step();
    drain(0);

    // Random vectors with random backpressure
    for (int v = 0; v < 20; v++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      rk = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      send(rp, rk, 0);
      drain(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
